// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants and word type for decode, writeback and regfile_sb.
package regfile_sb_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ZERO_IDX = 0;
    localparam int unsigned SP_IDX   = 29;
    localparam int unsigned RA_IDX   = 31;
    localparam int unsigned SP_INIT  = 2048;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/regfile_sb_rport.sv
// One register-file read port: write-to-read bypass plus busy qualification.
module regfile_sb_rport
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              arr_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic hit;

    assign hit = wr_en && (wr_addr == addr);

    // Register 0 is hard-wired to zero even when a write targets it.
    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (rst_n) begin
            if (addr != ADDR_W'(ZERO_IDX)) begin
                rd_data = hit ? wr_data : arr_data;
            end
            rd_busy = arr_busy && !hit;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file with NRD bypassed read ports and a pending-write scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NRD     = 2,
    parameter int unsigned SP_IDX  = regfile_sb_pkg::SP_IDX,
    parameter int unsigned SP_INIT = regfile_sb_pkg::SP_INIT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  alloc_valid,
    input  logic [ADDR_W-1:0]     alloc_addr,
    output logic                  alloc_ready,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              xfer;
    logic              inc;
    logic              dec;

    assign alloc_ready = RST && (!busy_q[alloc_addr] || (wr_en && (wr_addr == alloc_addr)));
    assign xfer        = alloc_valid && alloc_ready;
    assign inc         = xfer && (alloc_addr != ADDR_W'(ZERO_IDX));
    assign dec         = wr_en && (wr_addr != ADDR_W'(ZERO_IDX)) && busy_q[wr_addr];
    assign busy_cnt    = RST ? cnt_q : '0;

    // A reservation landing on the register being written wins over the clear.
    always_comb begin
        busy_nxt = busy_q;
        cnt_nxt  = cnt_q;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (inc) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
        busy_nxt[ZERO_IDX] = 1'b0;
        case ({inc, dec})
            2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
            2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
            default: cnt_nxt = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en && (wr_addr != ADDR_W'(ZERO_IDX))) begin
                regs[wr_addr] <= wr_data;
            end
            busy_q <= busy_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rport
        regfile_sb_rport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rport (
            .rst_n    (RST),
            .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
            .arr_data (regs[rd_addr[k*ADDR_W +: ADDR_W]]),
            .arr_busy (busy_q[rd_addr[k*ADDR_W +: ADDR_W]]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with default parameters (two read ports).
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;
    logic        alloc_ready;
    logic [5:0]  busy_cnt;

    int checks   = 0;
    int failures = 0;

    word_t rd0, rd1;
    assign rd0 = rd_data[31:0];
    assign rd1 = rd_data[63:32];

    regfile_sb dut (
        .CLK         (CLK),
        .RST         (RST),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .busy_cnt    (busy_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        RST = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_valid = 1'b0; alloc_addr = '0; set_rd(5'd29, 5'd5);

        // Reset with a write and an alloc that must both be ignored
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        cyc();
        #2;
        check("rst_alloc_ready", 64'(alloc_ready), 64'(0));
        check("rst_busy_cnt", 64'(busy_cnt), 64'(0));
        check("rst_rd_forced", 64'(rd0), 64'(0));
        check("rst_rd_busy", 64'(rd_busy), 64'(0));
        cyc();
        RST = 1'b1; wr_en = 1'b0; alloc_valid = 1'b0;
        #2;
        check("rst_sp", 64'(rd0), 64'(2048));
        check("rst_r5", 64'(rd1), 64'(0));
        check("rst_cnt_after", 64'(busy_cnt), 64'(0));
        check("rst_r3_free", 64'(alloc_ready), 64'(1));

        // Bypass
        cyc();
        set_rd(5'd8, 5'd29);
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF;
        #2;
        check("byp_same_cycle", 64'(rd0), 64'h0000_0000_DEAD_BEEF);
        check("byp_other_port", 64'(rd1), 64'(2048));
        cyc();
        wr_en = 1'b0;
        #2;
        check("byp_next_cycle", 64'(rd0), 64'h0000_0000_DEAD_BEEF);

        // Register 0
        cyc();
        set_rd(5'd0, 5'd8);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        #2;
        check("r0_no_bypass", 64'(rd0), 64'(0));
        cyc();
        wr_en = 1'b0; alloc_valid = 1'b1; alloc_addr = 5'd0;
        #2;
        check("r0_after_write", 64'(rd0), 64'(0));
        check("r0_alloc_ready", 64'(alloc_ready), 64'(1));
        cyc();
        alloc_valid = 1'b0;
        #2;
        check("r0_busy_cnt", 64'(busy_cnt), 64'(0));
        check("r0_rd_busy", 64'(rd_busy[0]), 64'(0));

        // Scoreboard RAW/WAW on register 12
        cyc();
        set_rd(5'd12, 5'd0);
        alloc_valid = 1'b1; alloc_addr = 5'd12;
        #2;
        check("sb_n_ready", 64'(alloc_ready), 64'(1));
        check("sb_n_not_busy", 64'(rd_busy[0]), 64'(0));
        cyc();
        #2;
        check("sb_n1_busy", 64'(rd_busy[0]), 64'(1));
        check("sb_n1_blocked", 64'(alloc_ready), 64'(0));
        check("sb_n1_cnt", 64'(busy_cnt), 64'(1));
        cyc();
        #2;
        check("sb_n2_blocked", 64'(alloc_ready), 64'(0));
        cyc();
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'd7;
        #2;
        check("sb_n3_busy_bypassed", 64'(rd_busy[0]), 64'(0));
        check("sb_n3_ready", 64'(alloc_ready), 64'(1));
        check("sb_n3_data", 64'(rd0), 64'(7));
        cyc();
        wr_en = 1'b0; alloc_valid = 1'b0;
        #2;
        check("sb_after_busy", 64'(rd_busy[0]), 64'(1));
        check("sb_after_cnt", 64'(busy_cnt), 64'(1));
        check("sb_after_data", 64'(rd0), 64'(7));

        // Concurrent write of busy reg 3 and alloc of reg 4
        cyc();
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        cyc();
        alloc_valid = 1'b0;
        #2;
        check("cc_pre_cnt", 64'(busy_cnt), 64'(2));
        cyc();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        alloc_valid = 1'b1; alloc_addr = 5'd4;
        cyc();
        wr_en = 1'b0; alloc_valid = 1'b0;
        set_rd(5'd3, 5'd4);
        #2;
        check("cc_cnt", 64'(busy_cnt), 64'(2));
        check("cc_busy3", 64'(rd_busy[0]), 64'(0));
        check("cc_busy4", 64'(rd_busy[1]), 64'(1));
        check("cc_data3", 64'(rd0), 64'h33);

        // Drain 12 and 4, then reserve 9, 10, 11
        cyc();
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'd1;
        cyc();
        wr_addr = 5'd4; wr_data = 32'd2;
        cyc();
        wr_en = 1'b0;
        #2;
        check("drain_cnt", 64'(busy_cnt), 64'(0));
        for (int a = 9; a <= 11; a++) begin
            cyc();
            alloc_valid = 1'b1; alloc_addr = 5'(a);
        end
        cyc();
        alloc_valid = 1'b0;
        #2;
        check("mid_pre_cnt", 64'(busy_cnt), 64'(3));

        // Reset mid-operation drops all reservations
        cyc();
        RST = 1'b0;
        cyc();
        RST = 1'b1;
        set_rd(5'd9, 5'd10);
        #2;
        check("mid_cnt", 64'(busy_cnt), 64'(0));
        check("mid_busy_9_10", 64'(rd_busy), 64'(0));
        set_rd(5'd29, 5'd11);
        #1;
        check("mid_busy_11", 64'(rd_busy[1]), 64'(0));
        check("mid_sp", 64'(rd0), 64'(2048));

        // Late writeback after reset is an ordinary write
        cyc();
        set_rd(5'd9, 5'd12);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        cyc();
        wr_en = 1'b0;
        #2;
        check("late_data", 64'(rd0), 64'h99);
        check("late_cnt", 64'(busy_cnt), 64'(0));
        check("late_r12_cleared", 64'(rd1), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated write scoreboard, placed in the decode stage of the MIPS pipeline.
- Provides NRD combinational read ports and one write port with same-cycle write-to-read bypass.
- Tracks per-register pending writes from long-latency units (MULT/DIV, loads), so decode can stall on RAW and WAW hazards.
- Replaces the fixed two-read-port file and generalises register count, data width and read-port count.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREG = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- SP_IDX, 29, stack-pointer register index
- SP_INIT, 2048, reset value of register SP_IDX

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data per port
- rd_busy  out  NRD  register at port k has a pending write
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- alloc_valid  in  1  request to mark alloc_addr pending
- alloc_addr  in  ADDR_W  register to reserve
- alloc_ready  out  1  reservation accepted this cycle
- busy_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Register 0 reads as 0 always. Writes to register 0 are discarded. An alloc to register 0 is accepted but sets no busy bit.
- Write: when wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0 at the edge.
- Read port k, combinational:
  - rd_data = wr_data if wr_en && wr_addr==rd_addr[k] && rd_addr[k]!=0; else reg[rd_addr[k]].
  - rd_busy = busy[rd_addr[k]] && !(wr_en && wr_addr==rd_addr[k]).
- Allocation handshake:
  - alloc_ready = !busy[alloc_addr] || (wr_en && wr_addr==alloc_addr).
  - A transfer occurs on alloc_valid && alloc_ready. On transfer, busy[alloc_addr] <= 1 (when alloc_addr!=0).
  - A blocked alloc (WAW) must be held by the requester; this block stores no request.
- Simultaneous wr_en and transfer to the same address: data is written and busy ends at 1, because alloc wins over clear.
- Writes to a non-busy register are legal and simply update data.
- busy_cnt: registered popcount of busy.
  - Increments on transfer to a non-zero address.
  - Decrements on a write that clears a set busy bit.
  - Both events on different addresses leave it unchanged; on the same address it is unchanged.

## Timing
- Reset (RST=0 at an edge):
  - All registers are cleared except reg[SP_IDX]=SP_INIT.
  - All busy bits and busy_cnt are cleared.
  - wr_en and alloc_valid in that cycle are ignored.
- While RST=0, outputs are forced: rd_data=0, rd_busy=0, alloc_ready=0, busy_cnt=0.
- Reset asserted mid-operation drops all pending reservations. Late writebacks after reset are ordinary writes.
- Read latency is 0 cycles. A write is visible to reads in the same cycle via bypass and from the array on the next cycle.
- An alloc transfer at edge N makes rd_busy=1 for that register from cycle N+1.
- alloc_ready is combinational from the alloc and write inputs and busy state; it has no path from rd_addr.

## Structure
- Shared package holds:
  - register index constants (ZERO_IDX=0, SP_IDX=29, RA_IDX=31)
  - SP_INIT
  - a DATA_W-wide word typedef
- Decode and writeback import these constants from the package; this block does not redefine them.
- Sub-module regfile_sb_rport: one read port containing the bypass mux and busy qualification, instantiated NRD times in a generate loop.
- Storage array, busy vector and busy_cnt stay in the top module.

## Test plan
- Reset:
  - Stimulus: drive RST=0 for 2 cycles, then read addresses 29 and 5.
  - Required: rd_data = 2048 and 0; busy_cnt = 0; alloc_ready = 0 during reset.
- Bypass:
  - Stimulus: wr_en=1, wr_addr=8, wr_data=0xDEADBEEF with rd_addr[0]=8 in the same cycle.
  - Required: rd_data[0]=0xDEADBEEF in that cycle, and the value is still read next cycle with wr_en=0.
- Register 0:
  - Stimulus: write 0x1234 to register 0, then alloc register 0.
  - Required: reads of register 0 return 0; alloc_ready=1; busy_cnt stays 0.
- Scoreboard RAW/WAW:
  - Stimulus: alloc 12 at cycle N; alloc 12 again at N+1; write 12 = 7 at N+3.
  - Required: rd_busy=1 from N+1; second alloc sees alloc_ready=0 until N+3; at N+3 the bypassed rd_busy=0 and alloc_ready=1; after that transfer rd_busy=1 again and busy_cnt=1.
- Concurrent events:
  - Stimulus: same cycle, write 3 (busy) and alloc 4.
  - Required: busy_cnt is unchanged, busy[3]=0, busy[4]=1.
- Reset mid-operation:
  - Stimulus: alloc 9, 10, 11 (busy_cnt=3), then pulse RST=0 for one cycle.
  - Required: busy_cnt=0, all rd_busy=0, reg[29]=2048.
